router_fsm_nch: RTL and testbench
=================================

Name: router_fsm_nch

Overview:
Parametrised successor to the router control FSM. It steers one packet at a time from the single input port to one of NUM_CH output FIFOs. It latches the destination from the header, gates writes through the load, full and parity states, and adds three behaviours: an invalid-address drop, a wait-till-empty timeout, and per-channel soft reset keyed to the latched destination. It sits between the input register block and the NUM_CH synchronizer/FIFO bank.

Parameters:
NUM_CH, 3, number of output channels (1..2**ADDR_W)
ADDR_W, 2, width of the header address field (data_in[ADDR_W-1:0])
WAIT_TIMEOUT, 32, cycles allowed in WAIT_TILL_EMPTY before the packet is dropped (>=2)

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  synchronous active-low reset
pkt_valid  in  1  packet valid from source
data_in  in  ADDR_W  header address bits (meaningful only in DECODE_ADDRESS)
fifo_full  in  1  full flag of the currently selected FIFO
fifo_empty  in  NUM_CH  per-channel empty flags
parity_done  in  1  parity byte captured (from register block)
low_pkt_valid  in  1  pkt_valid fell while in full handling (from register block)
soft_reset  in  NUM_CH  per-channel read-timeout soft reset
dest_sel  out  ADDR_W  latched destination channel
detect_add  out  1  state==DECODE_ADDRESS
lfd_state  out  1  state==LOAD_FIRST_DATA
ld_state  out  1  state==LOAD_DATA
full_state  out  1  state==FIFO_FULL_STATE
laf_state  out  1  state==LOAD_AFTER_FULL
rst_int_reg  out  1  state==CHECK_PARITY_ERROR
drop_state  out  1  state==DROP_PACKET
write_enb_reg  out  1  LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
busy  out  1  all states except DECODE_ADDRESS, LOAD_DATA, DROP_PACKET
timeout_err  out  1  one-cycle pulse on WAIT_TILL_EMPTY timeout

Behaviour:
- Reset: resetn=0 at a clock edge puts the FSM in DECODE_ADDRESS and clears dest_sel, the wait counter and timeout_err. After reset, detect_add=1 and all other outputs are 0.
- Outputs are registered state decodes; timeout_err is a registered pulse.
- Next-state priority: resetn, then soft reset, then the transition table below.
- Soft reset applies when soft_reset[dest_sel]=1 in any state except DECODE_ADDRESS; the next state is DECODE_ADDRESS. It is ignored in DECODE_ADDRESS, and soft_reset bits of non-selected channels are ignored.
- Address a is valid iff a < NUM_CH.
- DECODE_ADDRESS, when pkt_valid=1:
  - a invalid: go to DROP_PACKET.
  - a valid and fifo_empty[a]=1: go to LOAD_FIRST_DATA.
  - a valid and fifo_empty[a]=0: go to WAIT_TILL_EMPTY.
  - In both valid cases, dest_sel<=a on the same edge.
  - pkt_valid=0: stay.
- WAIT_TILL_EMPTY: uses the latched dest_sel, never data_in.
  - fifo_empty[dest_sel]=1: go to LOAD_FIRST_DATA and clear the counter.
  - Otherwise the counter increments. When it reaches WAIT_TIMEOUT-1 with the FIFO still non-empty, go to DROP_PACKET and assert timeout_err for exactly the following cycle.
  - Empty and timeout on the same cycle: empty wins.
- LOAD_FIRST_DATA: go to LOAD_DATA unconditionally.
- LOAD_DATA:
  - fifo_full=1: go to FIFO_FULL_STATE.
  - Else pkt_valid=0: go to LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE: stay while fifo_full=1, else go to LOAD_AFTER_FULL.
- LOAD_AFTER_FULL:
  - parity_done=1: go to DECODE_ADDRESS.
  - Else low_pkt_valid=1: go to LOAD_PARITY.
  - Else go to LOAD_DATA.
- LOAD_PARITY: go to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full=1 goes to FIFO_FULL_STATE, else DECODE_ADDRESS.
- DROP_PACKET: write_enb_reg=0 and busy=0, so the source keeps streaming and the bytes are discarded. Stay while pkt_valid=1; go to DECODE_ADDRESS on the first cycle pkt_valid=0. The trailing parity byte arrives while in DECODE_ADDRESS with pkt_valid=0 and is ignored.
- dest_sel holds its value outside DECODE_ADDRESS and is not cleared by soft reset.
- Every case arm assigns next state explicitly, so no latches are inferred.
- Unused state encodings go to DECODE_ADDRESS.

Test Plan:
- Header addr=1, fifo_empty=3'b111, 4 payload bytes -> state sequence DECODE, LFD, LD×4, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE; dest_sel=1; write_enb_reg high for 5 cycles; busy low during LD.
- Header addr=2, fifo_empty[2]=0 for 5 cycles then 1 -> 5 cycles in WAIT (busy=1), then LFD; dest_sel=2 while data_in is changed during WAIT.
- WAIT_TIMEOUT=8, fifo_empty[0] held 0 -> DROP_PACKET after 8 WAIT cycles; timeout_err=1 for exactly 1 cycle; no write_enb_reg.
- NUM_CH=3, header addr=3 -> DROP_PACKET next cycle, write_enb_reg=0 throughout, DECODE the cycle after pkt_valid falls.
- fifo_full=1 for 3 cycles mid-payload, low_pkt_valid=1 at release -> LD, FULL×3, LAF, LOAD_PARITY, CHECK_PARITY_ERROR.
- In LD with dest_sel=1: soft_reset=3'b100 -> no effect; soft_reset=3'b010 -> DECODE next cycle. resetn=0 during FULL -> DECODE next cycle with dest_sel=0.

Source files
------------

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: control FSM that steers one packet at a time from the input
// port to one of NUM_CH output FIFOs. It latches the header destination, gates
// FIFO writes through the load/full/parity states, drops packets with invalid
// addresses or an expired wait-till-empty, and honours per-channel soft reset.
module router_fsm_nch #(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic [NUM_CH-1:0] soft_reset,
    output logic [ADDR_W-1:0] dest_sel,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              full_state,
    output logic              laf_state,
    output logic              rst_int_reg,
    output logic              drop_state,
    output logic              write_enb_reg,
    output logic              busy,
    output logic              timeout_err
);

    localparam int NADDR = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(WAIT_TIMEOUT);

    typedef enum logic [3:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY,
        CHECK_PARITY_ERROR,
        DROP_PACKET
    } state_t;

    state_t             state;
    state_t             nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [NADDR-1:0]   empty_pad;
    logic [NADDR-1:0]   sreset_pad;
    logic               addr_ok;
    logic               wait_done;

    // Widen per-channel flags to the full address space so any address indexes safely
    always_comb begin
        empty_pad                = '0;
        empty_pad[NUM_CH-1:0]    = fifo_empty;
        sreset_pad               = '0;
        sreset_pad[NUM_CH-1:0]   = soft_reset;
        addr_ok   = ({1'b0, data_in} < (ADDR_W + 1)'(NUM_CH));
        wait_done = (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));
    end

    // Next-state selection: soft reset of the selected channel overrides the table
    always_comb begin
        nxt = DECODE_ADDRESS;
        case (state)
            DECODE_ADDRESS: begin
                if (!pkt_valid)              nxt = DECODE_ADDRESS;
                else if (!addr_ok)           nxt = DROP_PACKET;
                else if (empty_pad[data_in]) nxt = LOAD_FIRST_DATA;
                else                         nxt = WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_pad[dest_sel]) nxt = LOAD_FIRST_DATA;
                else if (wait_done)      nxt = DROP_PACKET;
                else                     nxt = WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       nxt = FIFO_FULL_STATE;
                else if (!pkt_valid) nxt = LOAD_PARITY;
                else                 nxt = LOAD_DATA;
            end
            FIFO_FULL_STATE: nxt = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (parity_done)        nxt = DECODE_ADDRESS;
                else if (low_pkt_valid) nxt = LOAD_PARITY;
                else                    nxt = LOAD_DATA;
            end
            LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET:        nxt = pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
            default:            nxt = DECODE_ADDRESS;
        endcase
        if (state != DECODE_ADDRESS && sreset_pad[dest_sel])
            nxt = DECODE_ADDRESS;
    end

    // State, destination latch, wait counter and registered output decodes
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= DECODE_ADDRESS;
            dest_sel      <= '0;
            wait_cnt      <= '0;
            timeout_err   <= 1'b0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            full_state    <= 1'b0;
            laf_state     <= 1'b0;
            rst_int_reg   <= 1'b0;
            drop_state    <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= nxt;
            if (state == DECODE_ADDRESS && pkt_valid && addr_ok)
                dest_sel <= data_in;
            // Counter only runs across consecutive WAIT cycles; any exit clears it
            if (state == WAIT_TILL_EMPTY && nxt == WAIT_TILL_EMPTY)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            timeout_err   <= (state == WAIT_TILL_EMPTY && nxt == DROP_PACKET);
            detect_add    <= (nxt == DECODE_ADDRESS);
            lfd_state     <= (nxt == LOAD_FIRST_DATA);
            ld_state      <= (nxt == LOAD_DATA);
            full_state    <= (nxt == FIFO_FULL_STATE);
            laf_state     <= (nxt == LOAD_AFTER_FULL);
            rst_int_reg   <= (nxt == CHECK_PARITY_ERROR);
            drop_state    <= (nxt == DROP_PACKET);
            write_enb_reg <= (nxt == LOAD_DATA || nxt == LOAD_PARITY ||
                              nxt == LOAD_AFTER_FULL);
            busy          <= !(nxt == DECODE_ADDRESS || nxt == LOAD_DATA ||
                               nxt == DROP_PACKET);
        end
    end

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: directed-vector bench for router_fsm_nch (NUM_CH=3,
// ADDR_W=2, WAIT_TIMEOUT=8). Each vector gives the inputs applied before a
// rising edge and the output pattern expected just after it.
module tb_router_fsm_nch;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] soft_reset;
    logic [1:0] dest_sel;
    logic       detect_add, lfd_state, ld_state, full_state, laf_state;
    logic       rst_int_reg, drop_state, write_enb_reg, busy, timeout_err;

    int tests  = 0;
    int failed = 0;

    // Output patterns {detect,lfd,ld,full,laf,rst_int,drop,wen,busy}
    localparam logic [8:0] S_DEC  = 9'b100000000;
    localparam logic [8:0] S_LFD  = 9'b010000001;
    localparam logic [8:0] S_LD   = 9'b001000010;
    localparam logic [8:0] S_FULL = 9'b000100001;
    localparam logic [8:0] S_LAF  = 9'b000010011;
    localparam logic [8:0] S_LP   = 9'b000000011;
    localparam logic [8:0] S_CPE  = 9'b000001001;
    localparam logic [8:0] S_WAIT = 9'b000000001;
    localparam logic [8:0] S_DROP = 9'b000000100;

    typedef struct packed {
        logic       rstn;
        logic       pv;
        logic [1:0] din;
        logic [2:0] empty;
        logic       full;
        logic       pd;
        logic       lpv;
        logic [2:0] sr;
        logic [9:0] exp_out;
        logic [1:0] exp_dest;
    } vec_t;

    router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(8)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .soft_reset(soft_reset), .dest_sel(dest_sel),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .drop_state(drop_state), .write_enb_reg(write_enb_reg), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    function automatic logic [9:0] obs();
        return {detect_add, lfd_state, ld_state, full_state, laf_state,
                rst_int_reg, drop_state, write_enb_reg, busy, timeout_err};
    endfunction

    function automatic vec_t mk(input logic rstn, input logic pv, input logic [1:0] din,
                                input logic [2:0] empty, input logic full, input logic pd,
                                input logic lpv, input logic [2:0] sr,
                                input logic [8:0] st, input logic to, input logic [1:0] d);
        vec_t v;
        v = '{rstn, pv, din, empty, full, pd, lpv, sr, {st, to}, d};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        resetn = v.rstn; pkt_valid = v.pv; data_in = v.din; fifo_empty = v.empty;
        fifo_full = v.full; parity_done = v.pd; low_pkt_valid = v.lpv; soft_reset = v.sr;
    endtask

    task automatic test_reset();
        vec_t v[$];
        v.push_back(mk(0, 1, 2'd1, 3'b111, 1, 1, 1, 3'b111, S_DEC, 0, 2'd0));
        v.push_back(mk(0, 0, 2'd0, 3'b000, 0, 0, 0, 3'b000, S_DEC, 0, 2'd0));
        foreach (v[i]) begin
            apply(v[i]); @(posedge clock); #1;
            tests++;
            if ({obs(), dest_sel} !== {v[i].exp_out, v[i].exp_dest}) begin
                failed++;
                $display("FAIL reset[%0d]: got out=%b dest=%0d, expected out=%b dest=%0d",
                         i, obs(), dest_sel, v[i].exp_out, v[i].exp_dest);
            end
        end
    endtask

    task automatic test_normal();
        vec_t v[$];
        v.push_back(mk(1, 1, 2'd1, 3'b111, 0, 0, 0, 3'b000, S_LFD, 0, 2'd1));
        repeat (4) v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LD, 0, 2'd1));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LP,  0, 2'd1));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_CPE, 0, 2'd1));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_DEC, 0, 2'd1));
        foreach (v[i]) begin
            apply(v[i]); @(posedge clock); #1;
            tests++;
            if ({obs(), dest_sel} !== {v[i].exp_out, v[i].exp_dest}) begin
                failed++;
                $display("FAIL normal[%0d]: got out=%b dest=%0d, expected out=%b dest=%0d",
                         i, obs(), dest_sel, v[i].exp_out, v[i].exp_dest);
            end
        end
    endtask

    task automatic test_wait();
        vec_t v[$];
        v.push_back(mk(1, 1, 2'd2, 3'b011, 0, 0, 0, 3'b000, S_WAIT, 0, 2'd2));
        repeat (4) v.push_back(mk(1, 1, 2'd0, 3'b011, 0, 0, 0, 3'b000, S_WAIT, 0, 2'd2));
        v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LFD, 0, 2'd2));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LD,  0, 2'd2));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LP,  0, 2'd2));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_CPE, 0, 2'd2));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_DEC, 0, 2'd2));
        foreach (v[i]) begin
            apply(v[i]); @(posedge clock); #1;
            tests++;
            if ({obs(), dest_sel} !== {v[i].exp_out, v[i].exp_dest}) begin
                failed++;
                $display("FAIL wait[%0d]: got out=%b dest=%0d, expected out=%b dest=%0d",
                         i, obs(), dest_sel, v[i].exp_out, v[i].exp_dest);
            end
        end
    endtask

    task automatic test_timeout();
        vec_t v[$];
        repeat (8) v.push_back(mk(1, 1, 2'd0, 3'b110, 0, 0, 0, 3'b000, S_WAIT, 0, 2'd0));
        v.push_back(mk(1, 1, 2'd1, 3'b110, 0, 0, 0, 3'b000, S_DROP, 1, 2'd0));
        v.push_back(mk(1, 1, 2'd1, 3'b110, 0, 0, 0, 3'b000, S_DROP, 0, 2'd0));
        v.push_back(mk(1, 0, 2'd1, 3'b110, 0, 0, 0, 3'b000, S_DEC,  0, 2'd0));
        foreach (v[i]) begin
            apply(v[i]); @(posedge clock); #1;
            tests++;
            if ({obs(), dest_sel} !== {v[i].exp_out, v[i].exp_dest}) begin
                failed++;
                $display("FAIL timeout[%0d]: got out=%b dest=%0d, expected out=%b dest=%0d",
                         i, obs(), dest_sel, v[i].exp_out, v[i].exp_dest);
            end
        end
    endtask

    task automatic test_invalid_addr();
        vec_t v[$];
        v.push_back(mk(1, 1, 2'd3, 3'b111, 0, 0, 0, 3'b000, S_DROP, 0, 2'd0));
        v.push_back(mk(1, 1, 2'd1, 3'b111, 0, 0, 0, 3'b000, S_DROP, 0, 2'd0));
        v.push_back(mk(1, 0, 2'd3, 3'b111, 0, 0, 0, 3'b000, S_DEC,  0, 2'd0));
        v.push_back(mk(1, 0, 2'd2, 3'b111, 0, 0, 0, 3'b000, S_DEC,  0, 2'd0));
        foreach (v[i]) begin
            apply(v[i]); @(posedge clock); #1;
            tests++;
            if ({obs(), dest_sel} !== {v[i].exp_out, v[i].exp_dest}) begin
                failed++;
                $display("FAIL invalid_addr[%0d]: got out=%b dest=%0d, expected out=%b dest=%0d",
                         i, obs(), dest_sel, v[i].exp_out, v[i].exp_dest);
            end
        end
    endtask

    task automatic test_full();
        vec_t v[$];
        // full for three cycles, released with low_pkt_valid
        v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LFD,  0, 2'd0));
        v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LD,   0, 2'd0));
        repeat (3) v.push_back(mk(1, 1, 2'd0, 3'b111, 1, 0, 0, 3'b000, S_FULL, 0, 2'd0));
        v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 0, 1, 3'b000, S_LAF,  0, 2'd0));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 1, 3'b000, S_LP,   0, 2'd0));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_CPE,  0, 2'd0));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_DEC,  0, 2'd0));
        // parity already captured when full releases
        v.push_back(mk(1, 1, 2'd1, 3'b111, 0, 0, 0, 3'b000, S_LFD,  0, 2'd1));
        v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LD,   0, 2'd1));
        v.push_back(mk(1, 1, 2'd0, 3'b111, 1, 0, 0, 3'b000, S_FULL, 0, 2'd1));
        v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 1, 0, 3'b000, S_LAF,  0, 2'd1));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 1, 0, 3'b000, S_DEC,  0, 2'd1));
        // fifo fills during the parity check
        v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LFD,  0, 2'd0));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LD,   0, 2'd0));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LP,   0, 2'd0));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 1, 0, 0, 3'b000, S_CPE,  0, 2'd0));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 1, 0, 0, 3'b000, S_FULL, 0, 2'd0));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 1, 0, 3'b000, S_LAF,  0, 2'd0));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 1, 0, 3'b000, S_DEC,  0, 2'd0));
        foreach (v[i]) begin
            apply(v[i]); @(posedge clock); #1;
            tests++;
            if ({obs(), dest_sel} !== {v[i].exp_out, v[i].exp_dest}) begin
                failed++;
                $display("FAIL full[%0d]: got out=%b dest=%0d, expected out=%b dest=%0d",
                         i, obs(), dest_sel, v[i].exp_out, v[i].exp_dest);
            end
        end
    endtask

    task automatic test_soft_reset();
        vec_t v[$];
        v.push_back(mk(1, 1, 2'd1, 3'b111, 0, 0, 0, 3'b010, S_LFD,  0, 2'd1));
        v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LD,   0, 2'd1));
        v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 0, 0, 3'b100, S_LD,   0, 2'd1));
        v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 0, 0, 3'b010, S_DEC,  0, 2'd1));
        v.push_back(mk(1, 1, 2'd1, 3'b111, 0, 0, 0, 3'b000, S_LFD,  0, 2'd1));
        v.push_back(mk(1, 1, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_LD,   0, 2'd1));
        v.push_back(mk(1, 1, 2'd0, 3'b111, 1, 0, 0, 3'b000, S_FULL, 0, 2'd1));
        v.push_back(mk(0, 1, 2'd0, 3'b111, 1, 0, 0, 3'b000, S_DEC,  0, 2'd0));
        v.push_back(mk(1, 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, S_DEC,  0, 2'd0));
        foreach (v[i]) begin
            apply(v[i]); @(posedge clock); #1;
            tests++;
            if ({obs(), dest_sel} !== {v[i].exp_out, v[i].exp_dest}) begin
                failed++;
                $display("FAIL soft_reset[%0d]: got out=%b dest=%0d, expected out=%b dest=%0d",
                         i, obs(), dest_sel, v[i].exp_out, v[i].exp_dest);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
        fifo_empty = '0; parity_done = 1'b0; low_pkt_valid = 1'b0; soft_reset = '0;
        @(negedge clock);
        test_reset();
        test_normal();
        test_wait();
        test_timeout();
        test_invalid_addr();
        test_full();
        test_soft_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
